// File: rtl/alarm_sched.sv
// alarm_sched: seconds-of-day tracker with alarm arm/ring/snooze/auto-stop sequencing.
// SOD is resynced from the POSIX counter by a 32-cycle restoring modulo after reset and every time load.
module alarm_sched #(
  parameter int SEC_IN_DAY = 86400,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3,
  localparam int CW = $clog2(MAX_SNOOZE + 1),
  localparam int TW = $clog2((RING_SEC > SNOOZE_SEC ? RING_SEC : SNOOZE_SEC) + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [31:0]   posix_time_i,
  input  logic          tick_i,
  input  logic          time_set_i,
  input  logic          alarm_en_i,
  input  logic [16:0]   alarm_time_i,
  input  logic          alarm_set_i,
  input  logic          snooze_i,
  input  logic          stop_i,
  output logic [16:0]   sod_o,
  output logic          sod_valid_o,
  output logic          ring_o,
  output logic [1:0]    state_o,
  output logic [CW-1:0] snooze_cnt_o,
  output logic          alarm_err_o
);
  localparam int SW = 17;
  localparam logic [SW-1:0] DAY     = SW'(SEC_IN_DAY);
  localparam logic [SW-1:0] LAST    = SW'(SEC_IN_DAY - 1);
  localparam logic [SW:0]   DAY_X   = {1'b0, DAY};
  localparam logic [TW-1:0] RING_T  = TW'(RING_SEC);
  localparam logic [TW-1:0] SNZ_T   = TW'(SNOOZE_SEC);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_SNOOZE);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RING = 2'd2, SNZ = 2'd3} state_t;

  logic          r_start, r_busy, r_pend, r_valid, r_err;
  logic [4:0]    r_cnt;
  logic [31:0]   r_div;
  logic [SW-1:0] r_rem, r_sod, r_alarm;
  logic [TW-1:0] r_tmr;
  logic [CW-1:0] r_scnt;
  state_t        r_state;

  logic [SW:0]   w_sh;
  logic [SW-1:0] w_red, w_red1, w_nxt, w_alarm_n;
  logic          w_tick, w_match, w_bad;
  logic [TW-1:0] w_tmr_n;
  logic [CW-1:0] w_scnt_n;
  state_t        w_state_n;

  assign w_sh    = {r_rem, r_div[31]};
  assign w_red   = (w_sh >= DAY_X) ? SW'(w_sh - DAY_X) : w_sh[SW-1:0];
  assign w_red1  = (w_red == LAST) ? '0 : w_red + 1'b1;
  assign w_nxt   = (r_sod == LAST) ? '0 : r_sod + 1'b1;
  // A tick coinciding with a time load belongs to the old time base and is dropped.
  assign w_tick  = tick_i & r_valid & ~time_set_i;
  assign w_match = w_tick & (w_nxt == r_alarm);
  assign w_bad   = alarm_time_i >= DAY;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_start <= 1'b1;
      r_busy  <= 1'b0;
      r_pend  <= 1'b0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
      r_div   <= '0;
      r_rem   <= '0;
      r_sod   <= '0;
    end else if (r_start | time_set_i) begin
      r_start <= 1'b0;
      r_busy  <= 1'b1;
      r_pend  <= 1'b0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
      r_div   <= posix_time_i;
      r_rem   <= '0;
    end else if (r_busy) begin
      r_div <= {r_div[30:0], 1'b0};
      r_rem <= w_red;
      r_cnt <= r_cnt + 1'b1;
      r_pend <= r_pend | tick_i;
      if (r_cnt == 5'd31) begin
        r_busy  <= 1'b0;
        r_valid <= 1'b1;
        r_sod   <= (r_pend | tick_i) ? w_red1 : w_red;
      end
    end else if (tick_i) begin
      r_sod <= w_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_tmr   <= '0;
      r_scnt  <= '0;
      r_alarm <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_tmr   <= w_tmr_n;
      r_scnt  <= w_scnt_n;
      r_alarm <= w_alarm_n;
      r_err   <= alarm_set_i & w_bad;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_tmr_n   = r_tmr;
    w_scnt_n  = r_scnt;
    w_alarm_n = r_alarm;
    if (!alarm_en_i) begin
      w_state_n = IDLE;
      w_scnt_n  = '0;
    end else if (alarm_set_i) begin
      if (!w_bad) begin
        w_alarm_n = alarm_time_i;
        w_state_n = ARMED;
        w_scnt_n  = '0;
      end
    end else begin
      case (r_state)
        IDLE: w_state_n = ARMED;
        ARMED: if (w_match) begin
          w_state_n = RING;
          w_tmr_n   = RING_T;
        end
        RING: if (stop_i) begin
          w_state_n = ARMED;
          w_scnt_n  = '0;
        end else if (snooze_i && r_scnt < MAX_CNT) begin
          w_state_n = SNZ;
          w_scnt_n  = r_scnt + 1'b1;
          w_tmr_n   = SNZ_T;
        end else if (w_tick) begin
          w_state_n = (r_tmr == 1) ? ARMED : RING;
          w_scnt_n  = (r_tmr == 1) ? '0 : r_scnt;
          w_tmr_n   = r_tmr - 1'b1;
        end
        default: if (stop_i) begin
          w_state_n = ARMED;
          w_scnt_n  = '0;
        end else if (w_tick) begin
          w_state_n = (r_tmr == 1) ? RING : SNZ;
          w_tmr_n   = (r_tmr == 1) ? RING_T : r_tmr - 1'b1;
        end
      endcase
    end
  end

  assign sod_o        = r_sod;
  assign sod_valid_o  = r_valid;
  assign ring_o       = r_state == RING;
  assign state_o      = r_state;
  assign snooze_cnt_o = r_scnt;
  assign alarm_err_o  = r_err;
endmodule
